// File: rtl/cpu_run_ctrl_if.sv
// Run-control bus between the board debug inputs and the CPU enable logic.
// The master drives the debug/breakpoint inputs; the slave returns enable and status.
interface cpu_run_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic                 debug_en;
  logic                 btn_step;
  logic [31:0]          pc;
  logic [31:0]          bp_addr;
  logic                 bp_valid;
  logic                 cpu_en;
  logic                 halted;
  logic                 step_done;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cycle_cnt;

  modport master (
    output debug_en, btn_step, pc, bp_addr, bp_valid,
    input  cpu_en, halted, step_done, state, cycle_cnt
  );

  modport slave (
    input  debug_en, btn_step, pc, bp_addr, bp_valid,
    output cpu_en, halted, step_done, state, cycle_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer producing the MIPS core clock enable.
// Define MIPS_BREAKPOINT_EN to build the PC breakpoint (BREAK state); otherwise it is absent.
module cpu_run_ctrl #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_run_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, STEP = 2'd2, BRK = 2'd3} state_e;

  localparam int          SW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [SW-1:0]        step_cnt_q, step_cnt_d;
  logic                 step_q, step_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 step_rise, bp_hit, cpu_en, step_done;

  assign step_d    = bus.btn_step;
  assign step_rise = bus.btn_step & ~step_q;

`ifdef MIPS_BREAKPOINT_EN
  logic bp_armed_q, bp_armed_d;

  assign bp_hit = bus.bp_valid & bp_armed_q & (bus.pc == bus.bp_addr);

  // Disarm on leaving BREAK so the core can execute past bp_addr; rearm once pc moves off it.
  always_comb begin
    bp_armed_d = bp_armed_q;
    if (state_q == BRK && state_d != BRK)
      bp_armed_d = 1'b0;
    else if (bus.pc != bus.bp_addr)
      bp_armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_armed_q <= 1'b1;
    else        bp_armed_q <= bp_armed_d;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_valid};
  assign bp_hit    = 1'b0;
`endif

  // Breakpoint masks the enable in the same cycle so the instruction at bp_addr never runs.
  assign cpu_en = ((state_q == RUN) & ~bp_hit) | (state_q == STEP);

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    step_done  = 1'b0;
    case (state_q)
      RUN: begin
        if (bp_hit)            state_d = BRK;
        else if (bus.debug_en) state_d = HALT;
      end
      HALT: begin
        if (!bus.debug_en) begin
          state_d = RUN;
        end else if (step_rise) begin
          state_d    = STEP;
          step_cnt_d = STEP_LOAD;
        end
      end
      STEP: begin
        // Button and breakpoint are ignored here: a step always runs to completion.
        if (step_cnt_q == '0) begin
          state_d   = bus.debug_en ? HALT : RUN;
          step_done = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q - 1'b1;
        end
      end
      BRK: begin
        if (step_rise) begin
          state_d    = bus.debug_en ? STEP : RUN;
          step_cnt_d = STEP_LOAD;
        end
      end
      default: state_d = HALT;
    endcase
  end

  assign cnt_d = cnt_q + CNT_WIDTH'(cpu_en);

  // step_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HALT;
      step_cnt_q <= '0;
      step_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.halted    = (state_q == HALT) | (state_q == BRK);
  assign bus.step_done = step_done;
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: three instances (1-cycle step, 4-cycle step, 4-bit counter)
// share clock, reset and inputs; each test checks the instance relevant to it.
module tb_cpu_run_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        debug_en = 1'b0, btn_step = 1'b0, bp_valid = 1'b0;
  logic [31:0] pc = '0, bp_addr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic        en;
    logic        done;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mcnt;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_WIDTH(32)) if1 ();
  cpu_run_ctrl_if #(.CNT_WIDTH(32)) if4 ();
  cpu_run_ctrl_if #(.CNT_WIDTH(4))  ifw ();

  assign if1.debug_en = debug_en; assign if1.btn_step = btn_step; assign if1.pc = pc;
  assign if1.bp_addr  = bp_addr;  assign if1.bp_valid = bp_valid;
  assign if4.debug_en = debug_en; assign if4.btn_step = btn_step; assign if4.pc = pc;
  assign if4.bp_addr  = bp_addr;  assign if4.bp_valid = bp_valid;
  assign ifw.debug_en = debug_en; assign ifw.btn_step = btn_step; assign ifw.pc = pc;
  assign ifw.bp_addr  = bp_addr;  assign ifw.bp_valid = bp_valid;

  cpu_run_ctrl #(.STEP_CYCLES(1), .CNT_WIDTH(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  cpu_run_ctrl #(.STEP_CYCLES(4), .CNT_WIDTH(32)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  cpu_run_ctrl #(.STEP_CYCLES(1), .CNT_WIDTH(4))  uw (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

  // Expected outputs for the current cycle; the model counter advances when enable is expected.
  task automatic push(input logic [1:0] st, input logic en, input logic done);
    exp_t e;
    e.st   = st;
    e.en   = en;
    e.done = done;
    e.hl   = (st == 2'd1) || (st == 2'd3);
    e.cnt  = mcnt;
    sb.push_back(e);
    mcnt = mcnt + {31'd0, en};
  endtask

  task automatic do_reset(input logic dbg, input logic btn);
    rst_n    = 1'b0;
    debug_en = dbg;
    btn_step = btn;
    bp_valid = 1'b0;
    pc       = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mcnt = '0;
  endtask

  task automatic test_reset;
    int st_t[5];
    exp_t e;
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if1.state, if1.cpu_en, if1.halted, if1.step_done, if1.cycle_cnt} !== {2'd1, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got st=%0d en=%b hl=%b done=%b cnt=%0d, want st=1 en=0 hl=1 done=0 cnt=0",
               if1.state, if1.cpu_en, if1.halted, if1.step_done, if1.cycle_cnt);
    end
    do_reset(1'b0, 1'b0);
    st_t = '{1, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      push(st_t[i][1:0], st_t[i] == 0, 1'b0);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({if1.state, if1.cpu_en, if1.step_done, if1.halted, if1.cycle_cnt} !== {e.st, e.en, e.done, e.hl, e.cnt}) begin
        n_fail++;
        $display("FAIL reset_release cyc%0d: got st=%0d en=%b done=%b hl=%b cnt=%0d, want st=%0d en=%b done=%b hl=%b cnt=%0d",
                 i, if1.state, if1.cpu_en, if1.step_done, if1.halted, if1.cycle_cnt, e.st, e.en, e.done, e.hl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_step;
    int   st_t[15];
    logic dbg_t[15], btn_t[15], dn_t[15];
    exp_t e;
    do_reset(1'b0, 1'b0);
    st_t  = '{1, 0, 0, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    dbg_t = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    btn_t = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    dn_t  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      debug_en = dbg_t[i];
      btn_step = btn_t[i];
      push(st_t[i][1:0], (st_t[i] == 0) || (st_t[i] == 2), dn_t[i]);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({if1.state, if1.cpu_en, if1.step_done, if1.halted, if1.cycle_cnt} !== {e.st, e.en, e.done, e.hl, e.cnt}) begin
        n_fail++;
        $display("FAIL halt_step cyc%0d: got st=%0d en=%b done=%b hl=%b cnt=%0d, want st=%0d en=%b done=%b hl=%b cnt=%0d",
                 i, if1.state, if1.cpu_en, if1.step_done, if1.halted, if1.cycle_cnt, e.st, e.en, e.done, e.hl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_step;
    int   st_t[16];
    logic dbg_t[16], btn_t[16], dn_t[16];
    exp_t e;
    do_reset(1'b1, 1'b0);
    st_t  = '{1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 2, 0, 0};
    dbg_t = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    btn_t = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    dn_t  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      debug_en = dbg_t[i];
      btn_step = btn_t[i];
      push(st_t[i][1:0], (st_t[i] == 0) || (st_t[i] == 2), dn_t[i]);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({if4.state, if4.cpu_en, if4.step_done, if4.halted, if4.cycle_cnt} !== {e.st, e.en, e.done, e.hl, e.cnt}) begin
        n_fail++;
        $display("FAIL multi_step cyc%0d: got st=%0d en=%b done=%b hl=%b cnt=%0d, want st=%0d en=%b done=%b hl=%b cnt=%0d",
                 i, if4.state, if4.cpu_en, if4.step_done, if4.halted, if4.cycle_cnt, e.st, e.en, e.done, e.hl, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      push((i == 0) ? 2'd1 : 2'd0, i != 0, 1'b0);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({ifw.state, ifw.cpu_en, ifw.cycle_cnt} !== {e.st, e.en, e.cnt[3:0]}) begin
        n_fail++;
        $display("FAIL cnt_wrap cyc%0d: got st=%0d en=%b cnt=%0d, want st=%0d en=%b cnt=%0d",
                 i, ifw.state, ifw.cpu_en, ifw.cycle_cnt, e.st, e.en, e.cnt[3:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_step;
    int   st_t[7];
    logic btn_t[7];
    exp_t e;
    do_reset(1'b1, 1'b0);
    btn_t = '{0, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      btn_step = btn_t[i];
      @(posedge clk); #1;
    end
    // Now two cycles into a 4-cycle step on u4.
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if4.state, if4.cpu_en, if4.halted, if4.step_done, if4.cycle_cnt} !== {2'd1, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_step: got st=%0d en=%b hl=%b done=%b cnt=%0d, want st=1 en=0 hl=1 done=0 cnt=0",
               if4.state, if4.cpu_en, if4.halted, if4.step_done, if4.cycle_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({if4.state, if4.step_done} !== {2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_hold: got st=%0d done=%b, want st=1 done=0", if4.state, if4.step_done);
    end
    rst_n = 1'b1;
    mcnt  = '0;
    st_t  = '{1, 1, 1, 1, 1, 1, 2};
    btn_t = '{1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      btn_step = btn_t[i];
      push(st_t[i][1:0], st_t[i] == 2, 1'b0);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({if4.state, if4.cpu_en, if4.step_done, if4.halted, if4.cycle_cnt} !== {e.st, e.en, e.done, e.hl, e.cnt}) begin
        n_fail++;
        $display("FAIL held_btn_after_rst cyc%0d: got st=%0d en=%b done=%b cnt=%0d, want st=%0d en=%b done=%b cnt=%0d",
                 i, if4.state, if4.cpu_en, if4.step_done, if4.cycle_cnt, e.st, e.en, e.done, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef MIPS_BREAKPOINT_EN
  task automatic test_breakpoint;
    int   st_t[13], pc_t[13];
    logic dbg_t[13], btn_t[13], en_t[13], dn_t[13];
    exp_t e;
    do_reset(1'b0, 1'b0);
    bp_addr  = 32'h10;
    bp_valid = 1'b1;
    st_t  = '{1, 0, 0, 3, 3, 0, 0, 0, 0, 3, 3, 2, 1};
    pc_t  = '{8, 12, 16, 16, 16, 16, 20, 24, 16, 16, 16, 16, 16};
    dbg_t = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    btn_t = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    en_t  = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
    dn_t  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 13; i++) begin
      debug_en = dbg_t[i];
      btn_step = btn_t[i];
      pc       = pc_t[i];
      push(st_t[i][1:0], en_t[i], dn_t[i]);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({if1.state, if1.cpu_en, if1.step_done, if1.halted, if1.cycle_cnt} !== {e.st, e.en, e.done, e.hl, e.cnt}) begin
        n_fail++;
        $display("FAIL breakpoint cyc%0d: got st=%0d en=%b done=%b hl=%b cnt=%0d, want st=%0d en=%b done=%b hl=%b cnt=%0d",
                 i, if1.state, if1.cpu_en, if1.step_done, if1.halted, if1.cycle_cnt, e.st, e.en, e.done, e.hl, e.cnt);
      end
      @(posedge clk); #1;
    end
    bp_valid = 1'b0;
  endtask
`else
  task automatic test_bp_disabled;
    exp_t e;
    do_reset(1'b0, 1'b0);
    bp_addr  = 32'h10;
    bp_valid = 1'b1;
    pc       = 32'h10;
    for (int i = 0; i < 5; i++) begin
      push((i == 0) ? 2'd1 : 2'd0, i != 0, 1'b0);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({if1.state, if1.cpu_en, if1.halted, if1.cycle_cnt} !== {e.st, e.en, e.hl, e.cnt}) begin
        n_fail++;
        $display("FAIL bp_disabled cyc%0d: got st=%0d en=%b hl=%b cnt=%0d, want st=%0d en=%b hl=%b cnt=%0d",
                 i, if1.state, if1.cpu_en, if1.halted, if1.cycle_cnt, e.st, e.en, e.hl, e.cnt);
      end
      @(posedge clk); #1;
    end
    bp_valid = 1'b0;
  endtask
`endif

  initial begin
    mcnt = '0;
    test_reset();
    test_halt_step();
    test_multi_step();
    test_wrap();
    test_rst_mid_step();
`ifdef MIPS_BREAKPOINT_EN
    test_breakpoint();
`else
    test_bp_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
